// File: rtl/biriscv_csr_issue_arb.sv
// CSR issue arbiter: grants one CSR-class op at a time from the two issue slots
// and holds further grants until the granted op has passed writeback.
module biriscv_csr_issue_arb #(
    parameter int unsigned WB_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_valid_i,
    input  logic [31:0] req0_opcode_i,
    input  logic [31:0] req0_pc_i,
    input  logic [31:0] req0_ra_operand_i,
    input  logic        req0_invalid_i,
    input  logic        req1_valid_i,
    input  logic [31:0] req1_opcode_i,
    input  logic [31:0] req1_pc_i,
    input  logic [31:0] req1_ra_operand_i,
    input  logic        req1_invalid_i,
    input  logic        squash_i,
    input  logic [5:0]  wb_exception_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    output logic        csr_valid_o,
    output logic [31:0] csr_opcode_o,
    output logic [31:0] csr_pc_o,
    output logic [31:0] csr_ra_operand_o,
    output logic        csr_invalid_o,
    output logic        csr_busy_o
);

    // state    | meaning
    // ST_RESET | held in reset, or first cycle after release (no grant)
    // ST_IDLE  | eligible to grant; slot0 has priority
    // ST_BUSY  | granted op in flight, counting down to writeback
    // ST_FLUSH | one-cycle gap after a trapping/fencing writeback
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [2:0] CNT_LOAD = 3'(WB_LATENCY);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       grant0, grant1;

    always_comb begin
        grant0  = (state_q == ST_IDLE) & req0_valid_i & ~squash_i;
        grant1  = (state_q == ST_IDLE) & req1_valid_i & ~req0_valid_i & ~squash_i;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                // squash is deliberately ignored here: the in-flight op always completes
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = (wb_exception_i != 6'd0) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RESET;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req0_ready_o     = grant0;
        req1_ready_o     = grant1;
        csr_valid_o      = grant0 | grant1;
        csr_busy_o       = (state_q == ST_BUSY) | (state_q == ST_FLUSH);
        csr_opcode_o     = 32'b0;
        csr_pc_o         = 32'b0;
        csr_ra_operand_o = 32'b0;
        csr_invalid_o    = 1'b0;
        if (grant0) begin
            csr_opcode_o     = req0_opcode_i;
            csr_pc_o         = req0_pc_i;
            csr_ra_operand_o = req0_ra_operand_i;
            csr_invalid_o    = req0_invalid_i;
        end else if (grant1) begin
            csr_opcode_o     = req1_opcode_i;
            csr_pc_o         = req1_pc_i;
            csr_ra_operand_o = req1_ra_operand_i;
            csr_invalid_o    = req1_invalid_i;
        end
    end

endmodule

// File: tb/tb_biriscv_csr_issue_arb.sv
// Bench for biriscv_csr_issue_arb: two instances (WB_LATENCY 2 and 1) on shared
// stimulus, checked against a cycle-number reference model through scoreboards.
module tb_biriscv_csr_issue_arb;

    typedef struct packed {
        logic r0;
        logic r1;
        logic v;
        logic busy;
    } exp_t;

    typedef struct packed {
        logic [31:0] op;
        logic [31:0] pc;
        logic [31:0] ra;
        logic        inv;
    } txn_t;

    localparam int N_CYC = 3000;

    logic        clk_i;
    logic        rst_ni;
    logic        req0_valid_i, req1_valid_i;
    logic [31:0] req0_opcode_i, req0_pc_i, req0_ra_operand_i;
    logic [31:0] req1_opcode_i, req1_pc_i, req1_ra_operand_i;
    logic        req0_invalid_i, req1_invalid_i;
    logic        squash_i;
    logic [5:0]  wb_exception_i;

    logic        r0_a, r1_a, v_a, inv_a, busy_a;
    logic [31:0] op_a, pc_a, ra_a;
    logic        r0_b, r1_b, v_b, inv_b, busy_b;
    logic [31:0] op_b, pc_b, ra_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_end[2];
    int   flush_cyc[2];
    bit   dead[2];
    exp_t eq0[$];
    exp_t eq1[$];
    txn_t tq0[$];
    txn_t tq1[$];

    biriscv_csr_issue_arb #(.WB_LATENCY(2)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i), .req0_pc_i(req0_pc_i),
        .req0_ra_operand_i(req0_ra_operand_i), .req0_invalid_i(req0_invalid_i),
        .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i), .req1_pc_i(req1_pc_i),
        .req1_ra_operand_i(req1_ra_operand_i), .req1_invalid_i(req1_invalid_i),
        .squash_i(squash_i), .wb_exception_i(wb_exception_i),
        .req0_ready_o(r0_a), .req1_ready_o(r1_a), .csr_valid_o(v_a),
        .csr_opcode_o(op_a), .csr_pc_o(pc_a), .csr_ra_operand_o(ra_a),
        .csr_invalid_o(inv_a), .csr_busy_o(busy_a)
    );

    biriscv_csr_issue_arb #(.WB_LATENCY(1)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i), .req0_pc_i(req0_pc_i),
        .req0_ra_operand_i(req0_ra_operand_i), .req0_invalid_i(req0_invalid_i),
        .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i), .req1_pc_i(req1_pc_i),
        .req1_ra_operand_i(req1_ra_operand_i), .req1_invalid_i(req1_invalid_i),
        .squash_i(squash_i), .wb_exception_i(wb_exception_i),
        .req0_ready_o(r0_b), .req1_ready_o(r1_b), .csr_valid_o(v_b),
        .csr_opcode_o(op_b), .csr_pc_o(pc_b), .csr_ra_operand_o(ra_b),
        .csr_invalid_o(inv_b), .csr_busy_o(busy_b)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h, required %h", nm, k, cyc, act, exp);
        end
    endtask

    // Reference: an op granted at cycle T occupies T+1..T+lat; a nonzero
    // exception seen at T+lat adds one more occupied cycle.
    task automatic model_step(input int k, input int lat);
        exp_t e;
        txn_t t;
        e = '0;
        if (!rst_ni) begin
            busy_end[k]  = -1;
            flush_cyc[k] = -1;
            dead[k]      = 1'b1;
        end else if (dead[k]) begin
            dead[k] = 1'b0;
        end else if (cyc <= busy_end[k]) begin
            e.busy = 1'b1;
            if (cyc == busy_end[k] && wb_exception_i != 6'd0) flush_cyc[k] = cyc + 1;
        end else if (cyc == flush_cyc[k]) begin
            e.busy = 1'b1;
        end else if (!squash_i && (req0_valid_i || req1_valid_i)) begin
            e.v         = 1'b1;
            busy_end[k] = cyc + lat;
            if (req0_valid_i) begin
                e.r0 = 1'b1;
                t = {req0_opcode_i, req0_pc_i, req0_ra_operand_i, req0_invalid_i};
            end else begin
                e.r1 = 1'b1;
                t = {req1_opcode_i, req1_pc_i, req1_ra_operand_i, req1_invalid_i};
            end
            if (k == 0) tq0.push_back(t);
            else        tq1.push_back(t);
        end
        if (k == 0) eq0.push_back(e);
        else        eq1.push_back(e);
    endtask

    task automatic mon(input int k, input logic r0, input logic r1, input logic v, input logic b,
                       input logic [31:0] op, input logic [31:0] pc, input logic [31:0] ra,
                       input logic inv);
        exp_t e;
        txn_t t;
        bit   have;
        if (k == 0) begin
            if (eq0.size() == 0) return;
            e = eq0.pop_front();
        end else begin
            if (eq1.size() == 0) return;
            e = eq1.pop_front();
        end
        chk("req0_ready", k, 32'(r0), 32'(e.r0));
        chk("req1_ready", k, 32'(r1), 32'(e.r1));
        chk("csr_valid",  k, 32'(v),  32'(e.v));
        chk("csr_busy",   k, 32'(b),  32'(e.busy));
        if (v) begin
            have = (k == 0) ? (tq0.size() != 0) : (tq1.size() != 0);
            n_cmp++;
            if (!have) begin
                n_bad++;
                $display("FAIL unexpected_grant dut%0d cycle %0d: got valid=1, required no pending op", k, cyc);
            end else begin
                if (k == 0) t = tq0.pop_front();
                else        t = tq1.pop_front();
                chk("csr_opcode",  k, op, t.op);
                chk("csr_pc",      k, pc, t.pc);
                chk("csr_ra",      k, ra, t.ra);
                chk("csr_invalid", k, 32'(inv), 32'(t.inv));
            end
        end else begin
            chk("idle_opcode", k, op, 32'h0);
            chk("idle_pc",     k, pc, 32'h0);
            chk("idle_ra",     k, ra, 32'h0);
            chk("idle_inv",    k, 32'(inv), 32'h0);
        end
    endtask

    always @(negedge clk_i) begin
        mon(0, r0_a, r1_a, v_a, busy_a, op_a, pc_a, ra_a, inv_a);
        mon(1, r0_b, r1_b, v_b, busy_b, op_b, pc_b, ra_b, inv_b);
    end

    task automatic async_chk(input string nm);
        chk({nm, "_busy"},  0, 32'(busy_a), 32'h0);
        chk({nm, "_valid"}, 0, 32'(v_a),    32'h0);
        chk({nm, "_ready"}, 0, 32'(r0_a | r1_a), 32'h0);
        chk({nm, "_busy"},  1, 32'(busy_b), 32'h0);
        chk({nm, "_valid"}, 1, 32'(v_b),    32'h0);
        chk({nm, "_ready"}, 1, 32'(r0_b | r1_b), 32'h0);
    endtask

    initial begin
        logic rst_next;
        int   rst_hold;
        rst_hold = 0;
        busy_end  = '{-1, -1};
        flush_cyc = '{-1, -1};
        dead      = '{1'b0, 1'b0};
        rst_ni = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_opcode_i = '0; req0_pc_i = '0; req0_ra_operand_i = '0; req0_invalid_i = 1'b0;
        req1_opcode_i = '0; req1_pc_i = '0; req1_ra_operand_i = '0; req1_invalid_i = 1'b0;
        squash_i = 1'b0;
        wb_exception_i = '0;
        #2 rst_ni = 1'b0;

        for (int c = 0; c < N_CYC; c++) begin
            @(posedge clk_i);
            #1;
            cyc = c;
            req0_opcode_i     = $urandom;
            req0_pc_i         = $urandom;
            req0_ra_operand_i = $urandom;
            req0_invalid_i    = 1'($urandom_range(0, 1));
            req1_opcode_i     = $urandom;
            req1_pc_i         = $urandom;
            req1_ra_operand_i = $urandom;
            req1_invalid_i    = 1'($urandom_range(0, 1));
            req0_valid_i   = 1'($urandom_range(0, 1));
            req1_valid_i   = 1'($urandom_range(0, 1));
            squash_i       = ($urandom_range(0, 6) == 0);
            wb_exception_i = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;

            if (c < 20) begin
                req0_valid_i = (c >= 3); req1_valid_i = (c >= 4);
                squash_i = 1'b0; wb_exception_i = 6'd0;
            end else if (c < 40) begin
                req0_valid_i = 1'b1; squash_i = 1'b0; wb_exception_i = 6'h2;
            end else if (c < 55) begin
                req0_valid_i = 1'b1; squash_i = 1'($urandom_range(0, 1));
            end else if (c < 60) begin
                req0_valid_i = (c == 59); req1_valid_i = 1'b0;
                squash_i = 1'b0; wb_exception_i = 6'd0;
            end else if (c < 64) begin
                req0_valid_i = 1'b1; squash_i = 1'b0;
            end else if (c < 80) begin
                req0_valid_i = 1'b0; req1_valid_i = 1'b1; squash_i = 1'b0;
            end

            if (c >= 100 && rst_hold == 0 && $urandom_range(0, 299) == 0) rst_hold = 2;
            rst_next = !(c < 3 || c == 60 || c == 61 || rst_hold > 0);
            if (rst_hold > 0) rst_hold--;

            if (c == 60) begin
                chk("pre_reset_busy", 0, 32'(busy_a), 32'h1);
                chk("pre_reset_busy", 1, 32'(busy_b), 32'h1);
            end
            if (rst_ni && !rst_next) begin
                rst_ni = 1'b0;
                #1;
                async_chk("async_reset");
            end else begin
                rst_ni = rst_next;
            end

            model_step(0, 2);
            model_step(1, 1);
        end

        @(negedge clk_i);
        #1;
        chk("txn_drained", 0, 32'(tq0.size()), 32'h0);
        chk("txn_drained", 1, 32'(tq1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
